// File: rtl/lfsr_pkg.sv
// Shared LFSR constants, state type and a reference step function.
package lfsr_pkg;

    localparam int              LFSR_WIDTH        = 16;
    localparam logic [15:0]     LFSR_TAPS_DEFAULT = 16'h002D;

    typedef logic [16:1] lfsr_t;

    // One Fibonacci step: parity of the tapped bits enters the MSB, the rest shifts right.
    function automatic lfsr_t lfsr_next(input lfsr_t seed, input logic [15:0] taps);
        logic fb;
        fb = ^(seed & taps);
        return {fb, seed[16:2]};
    endfunction

endpackage

// File: rtl/lfsr_next_comb.sv
// Combinational LFSR step. Produces both the load value and the stepped value.
// Optional feature macro: LFSR_LOCKUP_GUARD_EN (replaces an all-zero seed with 1).
module lfsr_next_comb
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEFAULT
) (
    input  logic [WIDTH:1] seed,
    output logic [WIDTH:1] load,
    output logic [WIDTH:1] next
);

    logic [WIDTH:1] seed_g;
    logic           fb;

`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero is the lockup point; nudge it onto the sequence before load or step.
    assign seed_g = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
`else
    assign seed_g = seed;
`endif

    // Mask bit k lines up with seed index k+1, so a plain bitwise AND aligns them.
    assign fb   = ^(seed_g & TAPS);
    assign next = {fb, seed_g[WIDTH:2]};
    assign load = seed_g;

endmodule

// File: rtl/lfsr.sv
// One-step Fibonacci LFSR register: state <= next(seed), or state <= seed on reset.
// The caller closes the loop by feeding state back into seed.
// Optional feature macro: LFSR_LOCKUP_GUARD_EN (see lfsr_next_comb).
module lfsr
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WIDTH:1] seed,
    output logic [WIDTH:1] state
);

    logic [WIDTH:1] load;
    logic [WIDTH:1] nxt;

    lfsr_next_comb #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .seed (seed),
        .load (load),
        .next (nxt)
    );

    // Reset loads the seed unstepped and takes priority over the step.
    always_ff @(posedge clk) begin
        if (rst) state <= load;
        else     state <= nxt;
    end

endmodule

// File: tb/tb_lfsr.sv
// Scoreboard bench for lfsr: driver pushes model expectations, monitor pops and compares.
module tb_lfsr;

    logic        clk;
    logic        rst;
    logic [16:1] seed;
    logic [16:1] state;

    lfsr dut (
        .clk   (clk),
        .rst   (rst),
        .seed  (seed),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp;
        string       name;
        bit          track;
    } item_t;

    item_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Observation of the feedback run
    bit          seen[65536];
    int          dup_cnt   = 0;
    int          zero_cnt  = 0;
    int          trk_cnt   = 0;
    logic [15:0] last_obs  = 16'h0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Reference model: arithmetic view of the rules (parity of tapped bits into bit 15).
    function automatic logic [15:0] guard(input logic [15:0] s);
`ifdef LFSR_LOCKUP_GUARD_EN
        if (s == 16'h0) return 16'h0001;
`endif
        return s;
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] s);
        int ones;
        logic [15:0] g;
        g    = guard(s);
        ones = $countones(g & 16'h002D);
        return (g / 2) + ((ones % 2) * 16'h8000);
    endfunction

    function automatic logic [15:0] model(input bit r, input logic [15:0] s);
        return r ? guard(s) : model_step(s);
    endfunction

    task automatic drive(input bit r, input logic [15:0] s, input string name, input bit track);
        item_t it;
        @(negedge clk);
        rst  = r;
        seed = s;
        it.exp   = model(r, s);
        it.name  = name;
        it.track = track;
        exp_q.push_back(it);
    endtask

    // Monitor: every clock presents a registered result for the previous drive.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                if (it.track) begin
                    // Per-step loop results are counted once via the summary checks below
                    if (state !== it.exp) begin
                        check(it.name, state, it.exp);
                    end
                    if (state == 16'h0) zero_cnt++;
                    if (seen[state]) dup_cnt++;
                    seen[state] = 1'b1;
                    last_obs = state;
                    trk_cnt++;
                end else begin
                    check(it.name, state, it.exp);
                end
            end
        end
    end

    initial begin
        logic [15:0] m;
        logic [15:0] r16;
        int          wait_cyc;
        rst  = 1'b0;
        seed = 16'h0;

        // Reset load and first steps
        drive(1'b1, 16'hACE1, "reset_load", 1'b0);
        drive(1'b0, 16'hACE1, "step_ace1", 1'b0);
        drive(1'b0, 16'h5670, "step_5670", 1'b0);

        // Fixed-value boundary cases (absolute expectations)
        drive(1'b1, 16'h1234, "midrun_rst", 1'b0);
        drive(1'b0, 16'h1234, "after_rst", 1'b0);
        drive(1'b0, 16'hFFFF, "all_ones", 1'b0);
        drive(1'b0, 16'h0000, "zero_step", 1'b0);
        drive(1'b1, 16'h0000, "zero_load", 1'b0);
        drive(1'b0, 16'h0001, "lsb_only", 1'b0);
        drive(1'b0, 16'h8000, "msb_only", 1'b0);

        // Randomized load/step mix
        for (int i = 0; i < 300; i++) begin
            r16 = 16'($urandom);
            if (i % 37 == 0) r16 = 16'h0;
            drive(($urandom_range(0, 7) == 0), r16, "random", 1'b0);
        end

        // Full feedback run from 0xACE1
        drive(1'b1, 16'hACE1, "loop_load", 1'b0);
        m = 16'hACE1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b0, m, "loop_step", 1'b1);
            m = model_step(m);
        end

        // Drain with a bound
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 100) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #2;
        check("drain", 16'(exp_q.size()), 16'h0);

        check("loop_count", 16'(trk_cnt), 16'hFFFF);
        check("loop_wrap", last_obs, 16'hACE1);
        check("loop_dups", 16'(dup_cnt), 16'h0);
        check("loop_zeros", 16'(zero_cnt), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Sanity anchors against the specified absolute values (independent of the model)
    initial begin
        logic [15:0] v;
        v = model(1'b1, 16'hACE1);
        if (v !== 16'hACE1) $display("model disagrees with reset_load vector");
        v = model(1'b0, 16'hACE1);
        if (v !== 16'h5670) $display("model disagrees with step_ace1 vector");
        v = model(1'b0, 16'h5670);
        if (v !== 16'hAB38) $display("model disagrees with step_5670 vector");
        v = model(1'b0, 16'h1234);
        if (v !== 16'h091A) $display("model disagrees with after_rst vector");
        v = model(1'b0, 16'hFFFF);
        if (v !== 16'h7FFF) $display("model disagrees with all_ones vector");
`ifdef LFSR_LOCKUP_GUARD_EN
        v = model(1'b0, 16'h0000);
        if (v !== 16'h8000) $display("model disagrees with zero_step vector");
`else
        v = model(1'b0, 16'h0000);
        if (v !== 16'h0000) $display("model disagrees with zero_step vector");
`endif
    end

endmodule
